// File: rtl/pingpong_sender.sv
// pingpong_sender
//   Producer side of the Sel/Data link. Incoming bytes are queued in a small
//   FIFO; two output banks alternate between "shown to the consumer" (the
//   bank addressed by sel) and "being refilled from the FIFO" (the other one).
//   A consumer switching onto a bank that never received fresh data is
//   flagged as an underrun and counted (saturating).
//
// Parameters
//   DEPTH : FIFO depth in bytes, power of two, >= 2
//   CNT_W : width of the saturating underrun counter
//
// Ports
//   clk          in   rising-edge clock shared with the consumer
//   rst          in   asynchronous active-low reset
//   in_data      in   byte to enqueue
//   in_valid     in   in_data valid
//   in_ready     out  FIFO can accept a byte (low while in reset)
//   sel          in   bank select from consumer (0: bank0, 1: bank1)
//   data         out  contents of the selected bank (combinational mux)
//   underrun     out  one-cycle pulse on a switch onto a stale bank
//   underrun_cnt out  saturating underrun event count
//   level        out  FIFO occupancy

module pingpong_sender #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sel,
  output logic [7:0]               data,
  output logic                     underrun,
  output logic [CNT_W-1:0]         underrun_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^PTR_W
  logic [7:0]       fifo_q [DEPTH];
  logic [7:0]       fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  // Output banks and per-bank "needs fresh data" flags
  logic [7:0]       bank_q [2];
  logic [7:0]       bank_d [2];
  logic [1:0]       pending_q, pending_d;

  // Previous sel for toggle detection, underrun pulse and counter
  logic             sel_q, sel_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

  // Per-cycle control
  logic             toggle;
  logic             refill_idx;
  logic             need;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  // in_ready is gated by rst so it drops the instant reset asserts.
  assign in_ready     = rst & (level_q != LVL_FULL);
  assign data         = sel ? bank_q[1] : bank_q[0];
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign level        = level_q;

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    bank_d         = bank_q;
    pending_d      = pending_q;
    sel_d          = sel;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;

    toggle     = sel ^ sel_q;
    refill_idx = ~sel;
    // The unselected bank is refilled when it is still waiting for data, or
    // when it was just deselected (its contents have been consumed).
    need       = pending_q[refill_idx] | toggle;
    fifo_empty = (level_q == '0);
    push       = in_valid & in_ready;
    pop        = need & ~fifo_empty;

    if (push) begin
      fifo_d[wr_ptr_q] = in_data;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end

    // Only the unselected bank is ever written; the head is read before any
    // same-cycle push lands, so there is no bypass path.
    if (pop) begin
      bank_d[refill_idx]    = fifo_q[rd_ptr_q];
      rd_ptr_d              = rd_ptr_q + PTR_ONE;
      pending_d[refill_idx] = 1'b0;
    end else if (need) begin
      pending_d[refill_idx] = 1'b1;
    end

    // Switching onto a bank still marked pending shows stale data. Its flag
    // is left set so it is refilled once it is deselected again.
    if (toggle && pending_q[sel]) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != '1) begin
        underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
      end
    end

    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      bank_q[0]      <= '0;
      bank_q[1]      <= '0;
      pending_q      <= '1;
      sel_q          <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      bank_q         <= bank_d;
      pending_q      <= pending_d;
      sel_q          <= sel_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

endmodule

// File: tb/tb_pingpong_sender.sv
// Testbench for pingpong_sender: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model of the link behaviour.

module tb_pingpong_sender;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [7:0]             in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   sel = 1'b0;
  logic                   in_ready;
  logic [7:0]             data;
  logic                   underrun;
  logic [CNT_W-1:0]       underrun_cnt;
  logic [$clog2(DEPTH):0] level;

  pingpong_sender #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sel          (sel),
    .data         (data),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .level        (level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte queue, two banks, stale flags, counters.
  logic [7:0] m_q[$];
  logic [7:0] m_bank[2];
  bit         m_pend[2];
  bit         m_selp;
  bit         m_ur;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bank[0] = 8'h00;
    m_bank[1] = 8'h00;
    m_pend[0] = 1'b1;
    m_pend[1] = 1'b1;
    m_selp    = 1'b0;
    m_ur      = 1'b0;
    m_cnt     = 0;
  endtask

  // Called away from the rising edge; returns at the following falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_level",    level,        0);
    chk("rst_data",     data,         8'h00);
    chk("rst_cnt",      underrun_cnt, 0);
    chk("rst_in_ready", in_ready,     0);
    chk("rst_underrun", underrun,     0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive inputs, check outputs against model, advance model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit s);
    bit tog, b, need, acc;
    in_valid = v;
    in_data  = d;
    sel      = s;
    #1;
    chk("data",         data,         s ? m_bank[1] : m_bank[0]);
    chk("in_ready",     in_ready,     32'(m_q.size() != DEPTH));
    chk("level",        level,        m_q.size());
    chk("underrun",     underrun,     32'(m_ur));
    chk("underrun_cnt", underrun_cnt, m_cnt);
    tog  = (s != m_selp);
    b    = !s;
    need = m_pend[b] || tog;
    acc  = v && (m_q.size() != DEPTH);
    m_ur = tog && m_pend[s];
    if (m_ur && m_cnt < 255) m_cnt++;
    if (need) begin
      if (m_q.size() > 0) begin
        m_bank[b] = m_q.pop_front();
        m_pend[b] = 1'b0;
      end else begin
        m_pend[b] = 1'b1;
      end
    end
    if (acc) m_q.push_back(d);
    m_selp = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit         rs;
    bit         acc;
    logic [7:0] nxt;
    int         guard;

    model_reset();
    @(negedge clk);

    // 1: reset, push A1..A3 with sel=0, then select bank1
    do_reset();
    cycle(1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("t1_data_sel0", data, 8'h00);
    sel = 1'b1;
    #1;
    chk("t1_data_a1", data, 8'hA1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // 2: consumer-style sel every 2 clocks, FIFO kept fed with 10..1F
    do_reset();
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    nxt   = 8'h13;
    guard = 0;
    while (nxt <= 8'h1F && guard < 200) begin
      acc = (m_q.size() != DEPTH);
      cycle(1'b1, nxt, 1'(((guard / 2) + 1) % 2));
      if (acc) nxt++;
      guard++;
    end
    chk("t2_all_pushed", 32'(nxt), 32'h20);
    chk("t2_cnt_zero", underrun_cnt, 0);

    // 3: two bytes only, three toggles; the third lands on a stale bank
    do_reset();
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t3_underrun", underrun, 1);
    chk("t3_cnt", underrun_cnt, 1);
    chk("t3_stale_data", data, 8'h31);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t3_pulse_end", underrun, 0);
    chk("t3_cnt_hold", underrun_cnt, 1);

    // 4: fill to full with sel held, then one toggle frees a slot
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    chk("t4_level_full", level, DEPTH);
    chk("t4_not_ready", in_ready, 0);
    cycle(1'b1, 8'h4F, 1'b0);
    chk("t4_no_overwrite", level, DEPTH);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t4_level_after_pop", level, DEPTH - 1);
    chk("t4_ready_again", in_ready, 1);
    chk("t4_data_first", data, 8'h40);

    // 5: starved consumer toggling every clock -> counter saturates
    do_reset();
    for (int i = 0; i < 260; i++) cycle(1'b0, 8'h00, 1'((i + 1) % 2));
    chk("t5_cnt_sat", underrun_cnt, 8'hFF);
    chk("t5_still_pulses", underrun, 1);
    cycle(1'b0, 8'h00, 1'b1);

    // 6: asynchronous reset mid-stream with three bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h61 + i), 1'b0);
    chk("t6_level_pre", level, 3);
    #2;
    do_reset();
    #1;
    chk("t6_ready_after", in_ready, 1);
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    sel = 1'b1;
    #1;
    chk("t6_first_out", data, 8'h77);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional resets
    do_reset();
    rs = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 1) == 0) rs = ~rs;
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), rs);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_sender.md
Name: pingpong_sender

Overview:
Upstream producer stage for the Sel/Data link. The downstream consumer drives `sel` from a free-running counter and samples `data` directly.
This block buffers incoming bytes in a small FIFO and keeps two output banks. The bank selected by `sel` drives `data`, while the other bank is refilled from the FIFO. Starvation is detected and counted.

Parameters:
- DEPTH, 4, FIFO depth in bytes; must be a power of 2 and at least 2.
- CNT_W, 8, width of the saturating underrun counter.

Ports:
- clk  input  1  rising-edge clock, shared with the consumer.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  byte to enqueue.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a byte.
- sel  input  1  bank select from the consumer: 0 selects bank0, 1 selects bank1.
- data  output  8  selected bank contents.
- underrun  output  1  one-cycle pulse: consumer switched onto a bank that was never refilled.
- underrun_cnt  output  CNT_W  saturating count of underrun events.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst=0):
  - FIFO empty, level=0, in_ready=0.
  - bank0=bank1=8'h00, pending[1:0]=2'b11, sel_q=0.
  - underrun=0, underrun_cnt=0.
- Outside reset, in_ready = (level != DEPTH).
- Push: `in_valid & in_ready` at a rising edge writes in_data at the write pointer. Pointers wrap modulo DEPTH.
- data = sel ? bank1 : bank0.
  - Combinational mux from registers, so it follows `sel` with zero latency.
  - A selected bank is never written.
- Toggle detect: toggle = (sel != sel_q). sel_q <= sel on every edge.
- Refill target: b = ~sel (the unselected bank). need = pending[b] | toggle.
- On each edge:
  - need & FIFO non-empty: bank[b] <= FIFO head; pop; pending[b] <= 0.
  - need & FIFO empty: pending[b] <= 1; bank[b] keeps its stale value.
  - toggle & pending[sel]=1: underrun <= 1 for one cycle; underrun_cnt increments, saturating at all-ones.
    - pending[sel] stays 1 (stale data is shown).
    - That bank is refilled only after it is deselected again.
- At most one pop per cycle. Push and pop in the same cycle are allowed: level is unchanged and pointers both advance.
- Latency:
  - A byte accepted at edge E0 can be loaded into the unselected bank at edge E1 at the earliest.
  - There is no FIFO bypass.
- Zero-bubble refill: on a toggle edge, the bank just deselected is reloaded on that same edge if the FIFO holds data.
- After reset:
  - bank0 is selected and pending, so data=0.
  - This is not counted as an underrun; underrun fires only on a toggle.
- Full: in_ready=0 and in_valid is ignored; no overwrite.
- Empty: no pop; pending stays set until data arrives or the bank becomes selected.
- Reset mid-operation: all state is cleared immediately and asynchronously; queued bytes are discarded.
- Order: bytes leave the FIFO strictly in acceptance order, alternating bank1, bank0, bank1, …, following the sel sequence.

Test Plan:
1. Reset with sel=0, then push A1,A2,A3 on back-to-back cycles.
   - Bank1 loads A1 one edge after its acceptance.
   - data=00 while sel=0, then data=A1 on the first sel=1.
2. Consumer-style sel (toggles every 2 clocks), FIFO kept non-empty, push 10..1F.
   - data reads 10,11,12,… in order with each value held 2 cycles.
   - underrun never asserts; underrun_cnt=0.
3. Push only 2 bytes, then let sel toggle 3 times.
   - Third toggle lands on a pending bank: underrun pulses once, underrun_cnt=1.
   - data shows the stale value (the earlier byte in that bank).
4. Hold sel constant, push DEPTH+2 bytes with in_valid=1.
   - One byte loads into the unselected bank, so after DEPTH+1 accepts level=DEPTH and in_ready=0.
   - The last byte is not accepted.
   - Toggle sel once: one pop, level=DEPTH-1, in_ready=1.
5. Force 260 underruns (FIFO empty, sel toggling).
   - underrun_cnt saturates at 8'hFF.
   - underrun still pulses on each event.
6. Assert rst mid-stream with level=3.
   - level=0, data=00, underrun_cnt=0 and in_ready=0 immediately, without waiting for a clock edge.
   - After release, in_ready=1.
   - The first pushed byte is the first byte out, to bank ~sel.
